// File: rtl/bcd_addsub_seq.sv
// bcd_addsub_seq: digit-serial multi-digit BCD adder/subtractor.
// Works on one BCD digit per clock, least significant digit first. A digit
// sum above 9 is corrected by adding 6 and generating a decimal carry.
// Operands come in through a valid/ready handshake. The result is held
// under an output valid/ready handshake until the consumer accepts it.
//
// Optional feature macro: BCD_SIGNMAG_EN
//   defined   -> a borrowing subtract is re-complemented serially in a FIX
//                state. The output is then the magnitude, with neg=1.
//   undefined -> subtract results are tens-complement; neg is always 0.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   in_valid  operands valid          in_ready  block can accept operands
//   a, b      packed BCD operands (digit 0 in bits [3:0])
//   sub       0: a+b+cin, 1: a-b     cin       decimal carry-in for add
//   out_valid result valid            out_ready consumer accepts result
//   sum       packed BCD result
//   cout      add: carry-out, sub: 1 = no borrow
//   neg       result is a negative magnitude
//   err       an input digit of a or b was above 9
module bcd_addsub_seq #(
  parameter int DIGITS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic              sub,
  input  logic              cin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4*DIGITS-1:0] sum,
  output logic              cout,
  output logic              neg,
  output logic              err
);

  localparam int W   = 4 * DIGITS;
  localparam int CW  = $clog2(DIGITS) + 1;
  localparam int TOP = W - 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
`ifdef BCD_SIGNMAG_EN
    , FIX = 2'd3
`endif
  } state_t;

  // One decimal digit step. Bit 4 is the carry and bits [3:0] are the digit.
  function automatic logic [4:0] bcd_digit(input logic [3:0] x, input logic [3:0] y, input logic c);
    logic [4:0] z;
    z = {1'b0, x} + {1'b0, y} + {4'd0, c};
    if (z > 5'd9) begin
      bcd_digit = {1'b1, z[3:0] + 4'd6};
    end else begin
      bcd_digit = {1'b0, z[3:0]};
    end
  endfunction

  // Nines' complement of every digit. Digits above 9 wrap deterministically.
  function automatic logic [W-1:0] nines(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'd9 - v[4*i +: 4];
    end
    return r;
  endfunction

  // Flag if any digit is outside the range 0..9.
  function automatic logic non_bcd(input logic [W-1:0] v);
    logic r;
    r = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) begin
        r = 1'b1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  state_t          state_r, state_s;
  logic [W-1:0]    a_r, a_s, b_r, b_s, acc_r, acc_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic            carry_r, carry_s;
  logic            errp_r, errp_s;
  logic [4:0]      res_s;
  logic            in_ready_r, in_ready_s, out_valid_r, out_valid_s;
  logic [W-1:0]    sum_r, sum_s;
  logic            cout_r, cout_s, neg_r, neg_s, err_r, err_s;
`ifdef BCD_SIGNMAG_EN
  logic            sub_r, sub_s;
`endif

  // Next-state and datapath decode for the digit-serial sequencer.
  always_comb begin
    state_s  = state_r;
    a_s      = a_r;
    b_s      = b_r;
    acc_s    = acc_r;
    cnt_s    = cnt_r;
    carry_s  = carry_r;
    errp_s   = errp_r;
    res_s    = 5'd0;
    sum_s    = sum_r;
    cout_s   = cout_r;
    neg_s    = neg_r;
    err_s    = err_r;
`ifdef BCD_SIGNMAG_EN
    sub_s    = sub_r;
`endif
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          a_s     = a;
          // Subtraction is A + nines(B) + 1, which is the tens complement of B.
          b_s     = sub ? nines(b) : b;
          carry_s = sub ? 1'b1 : cin;
          errp_s  = non_bcd(a) | non_bcd(b);
          acc_s   = '0;
          cnt_s   = '0;
`ifdef BCD_SIGNMAG_EN
          sub_s   = sub;
`endif
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        res_s   = bcd_digit(a_r[3:0], b_r[3:0], carry_r);
        // The new digit enters at the top, so digit 0 ends up at bits [3:0].
        acc_s   = (acc_r >> 3'd4) | (W'(res_s[3:0]) << TOP);
        a_s     = a_r >> 3'd4;
        b_s     = b_r >> 3'd4;
        carry_s = res_s[4];
        cnt_s   = cnt_r + CW'(1);
        if (cnt_r == CW'(DIGITS - 1)) begin
          cnt_s = '0;
`ifdef BCD_SIGNMAG_EN
          if (sub_r && !res_s[4]) begin
            // A borrow means the result is negative. Re-complement it to get
            // the magnitude. The +1 of the tens complement enters as carry.
            carry_s = 1'b1;
            state_s = FIX;
          end else begin
            sum_s   = acc_s;
            cout_s  = res_s[4];
            neg_s   = 1'b0;
            err_s   = errp_r;
            state_s = DONE;
          end
`else
          sum_s   = acc_s;
          cout_s  = res_s[4];
          neg_s   = 1'b0;
          err_s   = errp_r;
          state_s = DONE;
`endif
        end else begin
          state_s = RUN;
        end
      end
`ifdef BCD_SIGNMAG_EN
      FIX: begin
        res_s   = bcd_digit(4'd9 - acc_r[3:0], 4'd0, carry_r);
        acc_s   = (acc_r >> 3'd4) | (W'(res_s[3:0]) << TOP);
        carry_s = res_s[4];
        cnt_s   = cnt_r + CW'(1);
        if (cnt_r == CW'(DIGITS - 1)) begin
          cnt_s   = '0;
          sum_s   = acc_s;
          cout_s  = 1'b0;
          neg_s   = 1'b1;
          err_s   = errp_r;
          state_s = DONE;
        end else begin
          state_s = FIX;
        end
      end
`endif
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    in_ready_s  = (state_s == IDLE);
    out_valid_s = (state_s == DONE);
  end

  // State, working registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      a_r         <= '0;
      b_r         <= '0;
      acc_r       <= '0;
      cnt_r       <= '0;
      carry_r     <= 1'b0;
      errp_r      <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      sum_r       <= '0;
      cout_r      <= 1'b0;
      neg_r       <= 1'b0;
      err_r       <= 1'b0;
`ifdef BCD_SIGNMAG_EN
      sub_r       <= 1'b0;
`endif
    end else begin
      state_r     <= state_s;
      a_r         <= a_s;
      b_r         <= b_s;
      acc_r       <= acc_s;
      cnt_r       <= cnt_s;
      carry_r     <= carry_s;
      errp_r      <= errp_s;
      in_ready_r  <= in_ready_s;
      out_valid_r <= out_valid_s;
      sum_r       <= sum_s;
      cout_r      <= cout_s;
      neg_r       <= neg_s;
      err_r       <= err_s;
`ifdef BCD_SIGNMAG_EN
      sub_r       <= sub_s;
`endif
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign sum       = sum_r;
  assign cout      = cout_r;
  assign neg       = neg_r;
  assign err       = err_r;

endmodule

// File: tb/tb_bcd_addsub_seq.sv
// Testbench for bcd_addsub_seq with DIGITS=4. Random and directed operations
// are compared against a decimal-arithmetic reference model.
module tb_bcd_addsub_seq;

  localparam int D = 4;
  localparam int W = 4 * D;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         sub = 1'b0;
  logic         cin = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid, cout, neg, err;
  logic [W-1:0] sum;

  int n_tests = 0;
  int n_fail  = 0;

  bcd_addsub_seq #(.DIGITS(D)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .cin(cin), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .neg(neg), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic longint bcd2int(input logic [W-1:0] v);
    longint r = 0;
    for (int i = D - 1; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input longint v);
    logic [W-1:0] r = '0;
    longint t = v;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] r = '0;
    for (int i = 0; i < D; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  // Reference: plain decimal arithmetic on the operand values.
  task automatic model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic s, input logic c,
                       output logic [W-1:0] es, output logic ec, output logic en, output int el);
    longint x = bcd2int(av);
    longint y = bcd2int(bv);
    longint p = 1;
    longint t;
    for (int i = 0; i < D; i++) p = p * 10;
    en = 1'b0;
    el = D;
    if (!s) begin
      t  = x + y + longint'(c);
      es = int2bcd(t % p);
      ec = (t >= p);
    end else if (x >= y) begin
      es = int2bcd(x - y);
      ec = 1'b1;
    end else begin
`ifdef BCD_SIGNMAG_EN
      es = int2bcd(y - x);
      ec = 1'b0;
      en = 1'b1;
      el = 2 * D;
`else
      es = int2bcd(x - y + p);
      ec = 1'b0;
`endif
    end
  endtask

  // Present operands and return at #1 after the accepting edge.
  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic s, input logic c);
    int n = 0;
    @(negedge clk);
    a = av; b = bv; sub = s; cin = c; in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_val("accept_wait", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Wait for the result, check it, hold it for some cycles, then accept it.
  task automatic collect(input string tag, input logic [W-1:0] es, input logic ec, input logic en,
                         input logic eerr, input int el, input bit chk_sum, input int hold);
    int lat = 0;
    while (!out_valid && lat < 4 * D + 8) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_val({tag, "_latency"}, 64'(lat), 64'(el));
    if (chk_sum) begin
      check_val({tag, "_sum"}, 64'(sum), 64'(es));
      check_val({tag, "_cout"}, 64'(cout), 64'(ec));
      check_val({tag, "_neg"}, 64'(neg), 64'(en));
    end else begin
      check_val({tag, "_ready_low"}, 64'(in_ready), 64'd0);
    end
    check_val({tag, "_err"}, 64'(err), 64'(eerr));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check_val({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_val({tag, "_release_valid"}, 64'(out_valid), 64'd0);
    check_val({tag, "_release_ready"}, 64'(in_ready), 64'd1);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic s, input logic c, input int hold);
    logic [W-1:0] es;
    logic ec, en;
    int el;
    model(av, bv, s, c, es, ec, en, el);
    send(av, bv, s, c);
    collect(tag, es, ec, en, 1'b0, el, 1'b1, hold);
  endtask

  initial begin
    logic [W-1:0] es, es2, held;
    logic ec, en, ec2, en2;
    int el, el2, lat, seen;

    // Reset state.
    #12;
    check_val("rst_in_ready", in_ready, 1'b1);
    check_val("rst_out_valid", out_valid, 1'b0);
    check_val("rst_sum", sum, '0);
    check_val("rst_flags", {cout, neg, err}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases.
    run_op("add_basic", 16'h1234, 16'h5678, 1'b0, 1'b0, 0);
    run_op("add_wrap", 16'h9999, 16'h0000, 1'b0, 1'b1, 0);
    run_op("sub_noborrow", 16'h5000, 16'h1234, 1'b1, 1'b0, 0);
    run_op("sub_borrow", 16'h1234, 16'h5000, 1'b1, 1'b0, 0);
    run_op("sub_equal", 16'h4321, 16'h4321, 1'b1, 1'b1, 0);

    // Hold the result with out_ready low while a new request waits.
    model(16'h0456, 16'h0789, 1'b0, 1'b1, es, ec, en, el);
    model(16'h0800, 16'h0300, 1'b1, 1'b0, es2, ec2, en2, el2);
    send(16'h0456, 16'h0789, 1'b0, 1'b1);
    lat = 0;
    while (!out_valid && lat < 4 * D + 8) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_val("hold_latency", 64'(lat), 64'(el));
    check_val("hold_first_sum", sum, es);
    held = sum;
    a = 16'h0800; b = 16'h0300; sub = 1'b1; cin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check_val("hold_sum_stable", sum, held);
      check_val("hold_in_ready", in_ready, 1'b0);
      check_val("hold_out_valid", out_valid, 1'b1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_val("hold_release_ready", in_ready, 1'b1);
    check_val("hold_release_valid", out_valid, 1'b0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_val("hold_next_accepted", in_ready, 1'b0);
    collect("hold_next", es2, ec2, en2, 1'b0, el2, 1'b1, 0);

    // Non-BCD digit raises err. The sum value is left unchecked.
    send(16'h00A0, 16'h0000, 1'b0, 1'b0);
    collect("err_flag", '0, 1'b0, 1'b0, 1'b1, D, 1'b0, 0);
    run_op("err_clear", 16'h2468, 16'h1357, 1'b0, 1'b0, 0);

    // Reset two cycles into RUN clears everything and hides the aborted op.
    send(16'h1111, 16'h2222, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("abort_out_valid", out_valid, 1'b0);
    check_val("abort_in_ready", in_ready, 1'b1);
    check_val("abort_sum", sum, '0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 2 * D + 4; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check_val("abort_hidden", 64'(seen), 64'd0);

    // Randomized operations.
    for (int i = 0; i < 30; i++) begin
      run_op("rand", rand_bcd(), rand_bcd(), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d expected %0d", 1, 0);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bcd_addsub_seq.md
Name: bcd_addsub_seq

Overview:
Parametrised, digit-serial multi-digit BCD adder/subtractor. It processes one BCD digit per clock, least significant digit first, with decimal correction: if the 5-bit digit sum is greater than 9, add 6 and carry 1. Operands are captured through a valid/ready input handshake, and the result is held under an output handshake. It is the next generation of the team's single-digit combinational BCD adder and is used by the decimal datapath, e.g. counters and display accumulators.

Parameters:
DIGITS, 4, number of BCD digits per operand (≥1); operand width W = 4*DIGITS.
CW, clog2(DIGITS)+1, digit-counter width (derived localparam, not overridable).

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  reset, asynchronous and active-low.
in_valid  input  1  operands valid.
in_ready  output  1  block can accept operands.
a  input  W  operand A, packed BCD, digit 0 in a[3:0].
b  input  W  operand B, packed BCD.
sub  input  1  0 = A+B+cin; 1 = A−B (cin ignored).
cin  input  1  decimal carry-in for add.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts result.
sum  output  W  packed BCD result.
cout  output  1  add: decimal carry-out; sub: 1 = no borrow (A≥B).
neg  output  1  result negative (only meaningful with the optional feature).
err  output  1  at least one input digit of A or B was >9 (non-BCD).

Behaviour:
- Reset, asynchronous, active-low:
  - State = IDLE; in_ready=1; out_valid=0; sum=0; cout=0; neg=0; err=0; internal registers cleared.
  - Reset mid-operation aborts the current operation; no partial result is ever presented.
- FSM states: IDLE, RUN, (FIX, with the optional feature only), DONE.
- IDLE:
  - in_ready=1.
  - When in_valid&&in_ready, capture a, b, sub, and carry.
  - Initial carry = sub ? 1 : cin.
  - B digits are stored as nines' complement (9−d) when sub=1.
  - err is computed from the raw inputs at capture.
  - digit counter = 0; go to RUN.
- RUN, one digit per cycle:
  - z = a_d + b'_d + carry (5 bits).
  - If z>9: digit = z+6 (low 4 bits), carry=1; else digit = z, carry=0.
  - Shift the digit into the result register from the top (shift-right), so after DIGITS cycles digit 0 sits at sum[3:0].
  - When counter == DIGITS−1: cout = final carry, go to DONE (or to FIX, see Optional Feature).
- Non-BCD digits: computation proceeds with the same correction rule; err=1; the value is unspecified but deterministic.
- DONE:
  - out_valid=1; sum, cout, neg, err held stable.
  - in_ready=0 (no overlap between operations).
  - On out_ready=1, go to IDLE the next cycle with out_valid=0.
  - sum, cout, neg, err retain their values until the next result.
- Latency: acceptance at edge k gives out_valid=1 after edge k+DIGITS. Throughput is one operation per DIGITS+2 cycles when out_ready is held high.
- out_ready while not out_valid: ignored. in_valid outside IDLE: ignored; the producer holds its data until it sees in_ready.
- Subtraction without the feature: sum = tens-complement result. Example: 1234−5000 → 6234 with cout=0; neg=0 always.

Optional Feature:
BCD_SIGNMAG_EN:
- Defined:
  - After RUN, if sub=1 and the final carry=0 (borrow), enter FIX for DIGITS cycles.
  - FIX re-complements the result serially (tens complement: 9−d, +1 at digit 0, same correction rule).
  - The output becomes the magnitude with neg=1; cout=0.
  - Latency for a borrowing subtract becomes 2*DIGITS. All other cases are unchanged.
- Undefined:
  - FIX state and its logic are absent; neg is tied to 0.
  - Tens-complement output as described in Behaviour.

Test Plan:
- DIGITS=4, add: a=0x1234, b=0x5678, cin=0 → sum=0x6912, cout=0, err=0; out_valid exactly 4 cycles after acceptance.
- Add with carry wrap: a=0x9999, b=0x0000, cin=1 → sum=0x0000, cout=1.
- Subtract, no borrow: a=0x5000, b=0x1234, sub=1 → sum=0x3766, cout=1, neg=0.
- Subtract with borrow: a=0x1234, b=0x5000, sub=1:
  - without BCD_SIGNMAG_EN → sum=0x6234, cout=0, neg=0, latency 4;
  - with it → sum=0x3766, neg=1, latency 8.
- Handshake, back-to-back: hold out_ready=0 for 5 cycles after out_valid → sum stable, in_ready=0, a new in_valid is ignored. Then release → next operation accepted 1 cycle later.
- Error flag and reset: a=0x00A0 → err=1. Assert rst_n=0 two cycles into RUN → out_valid=0, in_ready=1, sum=0 immediately (asynchronous); the aborted operation never appears on the output.
